// File: rtl/opcode_packer.sv
// opcode_packer: packs three 32-bit command words into one 96-bit opcode for the GPU opcode FIFO.
// Optional partial-opcode idle timeout is enabled with OPCODE_PACKER_TIMEOUT_EN.
module opcode_packer #(
  parameter int WORD_W         = 32,
  parameter int WORDS          = 3,
  parameter int OPCODE_W       = 96,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_ready,
  input  logic                fifo_full,
  output logic                w_enable,
  output logic [OPCODE_W-1:0] w_data,
  output logic                busy,
  output logic [CNT_W-1:0]    opcode_count,
  output logic                timeout_err
);

  localparam logic [1:0] WORD0 = 2'd0;
  localparam logic [1:0] WORD1 = 2'd1;
  localparam logic [1:0] WORD2 = 2'd2;
  localparam logic [1:0] PUSH  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [OPCODE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic                partial;
  logic                expire;

  assign word_ready   = (state_q != PUSH) && !clear;
  assign accept       = word_valid && word_ready;
  // rst gating keeps a reset cycle from writing a stale opcode
  assign w_enable     = (state_q == PUSH) && !fifo_full && !clear && !rst;
  assign busy         = (state_q != WORD0);
  assign partial      = (state_q == WORD1) || (state_q == WORD2);
  assign w_data       = data_q;
  assign opcode_count = cnt_q;

`ifdef OPCODE_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          terr_q, terr_d;

  assign expire      = partial && !accept && (idle_q == IDLE_LAST);
  assign timeout_err = terr_q;

  always_comb begin
    idle_d = '0;
    terr_d = terr_q | expire;
    if (partial && !accept && !expire) begin
      idle_d = idle_q + TW'(1);
    end
    if (clear) begin
      idle_d = '0;
      terr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      terr_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      terr_q <= terr_d;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // first accepted word lands in the most significant slot
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WORD0: begin
        if (accept) begin
          data_d[OPCODE_W-1 -: WORD_W] = word_data;
          state_d = WORD1;
        end
      end
      WORD1: begin
        if (accept) begin
          data_d[OPCODE_W-WORD_W-1 -: WORD_W] = word_data;
          state_d = WORD2;
        end else if (expire) begin
          state_d = WORD0;
        end
      end
      WORD2: begin
        if (accept) begin
          data_d[WORD_W-1:0] = word_data;
          state_d = PUSH;
        end else if (expire) begin
          state_d = WORD0;
        end
      end
      default: begin
        if (w_enable) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WORD0;
        end
      end
    endcase
    if (clear) begin
      state_d = WORD0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WORD0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_opcode_packer.sv
// tb_opcode_packer: scoreboard bench for opcode_packer with a queue-based reference model.
// Timeout expectations follow OPCODE_PACKER_TIMEOUT_EN.
module tb_opcode_packer;

  localparam int TO = 8;
`ifdef OPCODE_PACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        fifo_full;
  logic        w_enable;
  logic [95:0] w_data;
  logic        busy;
  logic [15:0] opcode_count;
  logic        timeout_err;

  opcode_packer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .fifo_full    (fifo_full),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .busy         (busy),
    .opcode_count (opcode_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model: accepted words of the current opcode, pending opcode flag
  logic [31:0] part[$];
  logic [95:0] sb[$];
  logic [95:0] fq[$];
  bit          pend = 1'b0;
  int          cnt  = 0;
  int          idle = 0;
  bit          terr = 1'b0;
  bit          m_acc = 1'b0;
  bit          mon_on = 1'b0;
  bit          force_full = 1'b0;

  function automatic void chk(string name, logic [95:0] act,
                              logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst || clear) begin
      part.delete();
      sb.delete();
      pend = 1'b0;
      cnt  = 0;
      idle = 0;
      terr = 1'b0;
    end else if (pend) begin
      if (!fifo_full) begin
        pend = 1'b0;
        cnt  = (cnt + 1) % 65536;
        sb.delete();
      end
    end else if (word_valid) begin
      m_acc = 1'b1;
      idle  = 0;
      part.push_back(word_data);
      if (part.size() == 3) begin
        sb.push_back({part[0], part[1], part[2]});
        pend = 1'b1;
        part.delete();
      end
    end else if (TO_EN && part.size() > 0) begin
      idle++;
      if (idle == TO) begin
        part.delete();
        idle = 0;
        terr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit e_ready;
    bit e_wen;
    bit e_busy;
    if (mon_on) begin
      e_ready = !pend && !clear;
      e_wen   = pend && !fifo_full && !clear && !rst;
      e_busy  = pend || (part.size() > 0);
      chk("word_ready", 96'(word_ready), 96'(e_ready));
      chk("w_enable", 96'(w_enable), 96'(e_wen));
      chk("busy", 96'(busy), 96'(e_busy));
      chk("opcode_count", 96'(opcode_count), 96'(cnt));
      chk("timeout_err", 96'(timeout_err), 96'(terr));
      if (w_enable) begin
        if (fq.size() >= 4) begin
          checks++;
          fails++;
          $display("FAIL fifo_overflow: push with %0d entries", fq.size());
        end
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_push: w_data %h, none expected", w_data);
        end else begin
          chk("w_data", w_data, sb.pop_front());
        end
        fq.push_back(w_data);
      end
    end
  end

  task automatic tick(input bit rd);
    logic [95:0] dump;
    @(posedge clk);
    #1;
    if (rst) fq.delete();
    else if (rd && fq.size() > 0) dump = fq.pop_front();
    fifo_full = force_full || (fq.size() >= 4);
  endtask

  task automatic idle_n(input int n);
    word_valid = 1'b0;
    repeat (n) tick(1'b0);
  endtask

  task automatic send_word(input logic [31:0] d);
    bit done;
    done = 1'b0;
    word_valid = 1'b1;
    word_data  = d;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1'b0);
      done = m_acc;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_word: %h not accepted within 40 cycles", d);
    end
  endtask

  task automatic do_reset();
    word_valid = 1'b0;
    clear = 1'b0;
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    fifo_full = 1'b0;
    tick(1'b0);
    mon_on = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    chk("reset_w_data", w_data, 96'h0);
    chk("reset_ready", 96'(word_ready), 96'h1);

    // single opcode
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    idle_n(2);
    chk("t1_fifo_data", fq[fq.size()-1],
        96'h111111112222222233333333);
    chk("t1_count", 96'(opcode_count), 96'd1);
    chk("t1_busy", 96'(busy), 96'd0);

    // stall on full
    force_full = 1'b1;
    send_word(32'h44444444);
    send_word(32'h55555555);
    send_word(32'h66666666);
    idle_n(5);
    chk("t2_ready_stall", 96'(word_ready), 96'd0);
    chk("t2_count_stall", 96'(opcode_count), 96'd1);
    force_full = 1'b0;
    idle_n(3);
    chk("t2_count", 96'(opcode_count), 96'd2);
    chk("t2_fifo_len", 96'(fq.size()), 96'd2);

    // five opcodes into a FIFO with no reads
    do_reset();
    for (int i = 0; i < 15; i++) send_word(32'h100 + i);
    idle_n(3);
    chk("t3_fifo_len", 96'(fq.size()), 96'd4);
    chk("t3_stalled", 96'(word_ready), 96'd0);
    tick(1'b1);
    idle_n(2);
    chk("t3_fifo_len2", 96'(fq.size()), 96'd4);
    chk("t3_last", fq[fq.size()-1],
        {32'h10C, 32'h10D, 32'h10E});
    chk("t3_count", 96'(opcode_count), 96'd5);

    // clear discards a partial opcode
    do_reset();
    send_word(32'hDEAD0001);
    send_word(32'hDEAD0002);
    word_valid = 1'b0;
    clear = 1'b1;
    tick(1'b0);
    clear = 1'b0;
    send_word(32'hA);
    send_word(32'hB);
    send_word(32'hC);
    idle_n(2);
    chk("t4_fifo_len", 96'(fq.size()), 96'd1);
    chk("t4_data", fq[0], 96'h0000000A0000000B0000000C);
    chk("t4_count", 96'(opcode_count), 96'd1);

    // reset in WORD2 and in PUSH
    send_word(32'h1);
    send_word(32'h2);
    do_reset();
    chk("t5a_busy", 96'(busy), 96'd0);
    chk("t5a_w_data", w_data, 96'h0);
    send_word(32'h3);
    send_word(32'h4);
    send_word(32'h5);
    do_reset();
    chk("t5b_busy", 96'(busy), 96'd0);
    chk("t5b_count", 96'(opcode_count), 96'd0);
    chk("t5b_w_data", w_data, 96'h0);

    // idle timeout on a partial opcode
    send_word(32'hAAAA0001);
    idle_n(TO);
    chk("t6_terr", 96'(timeout_err), 96'(TO_EN));
    chk("t6_busy", 96'(busy), 96'(!TO_EN));
    send_word(32'hBBBB0001);
    send_word(32'hBBBB0002);
    send_word(32'hBBBB0003);
    idle_n(3);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rd;
      rd = ($urandom % 3) == 0;
      if (rst || clear || !word_valid || m_acc) begin
        word_valid = ($urandom % 4) != 0;
        word_data  = $urandom;
      end
      rst   = ($urandom % 300) == 0;
      clear = ($urandom % 80) == 0;
      if (($urandom % 60) == 0) word_valid = 1'b0;
      if (($urandom % 20) == 0) idle_n(TO + 1);
      tick(rd);
      rst = 1'b0;
      clear = 1'b0;
    end
    idle_n(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
